// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp
//
// Parametrised general-purpose register file for the pipelined MIPS-lite core.
//
//   * NUM_RD combinational read ports, each with same-cycle write bypass.
//   * Optional hardwired zero register (ZERO_REG=1): reg 0 reads as 0, is
//     never written and is never pending.
//   * After reset, a sequential clear engine writes 0 to every register,
//     one per clock. init_busy is high until the last register is cleared.
//     While it is high, reads return 0, rd_pend is 0, and writes and
//     pend_set are ignored.
//   * One pending bit per register, used by decode for hazard stalls.
//     pend_set marks a register. A write clears its bit. If both hit the
//     same register on the same edge, the set wins.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   wen        in   write enable (writeback stage)
//   waddr      in   [ADDR_W]         write address
//   wdata      in   [DATA_W]         write data
//   raddr      in   [NUM_RD*ADDR_W]  read addresses; port k at [k*ADDR_W +: ADDR_W]
//   rdata      out  [NUM_RD*DATA_W]  read data;      port k at [k*DATA_W +: DATA_W]
//   rd_pend    out  [NUM_RD]         addressed register awaits an in-flight write
//   pend_set   in   mark pend_addr pending
//   pend_addr  in   [ADDR_W]         register to mark pending
//   init_busy  out  clear engine active; core must stall
// -----------------------------------------------------------------------------
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wen,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic [NUM_RD-1:0]        rd_pend,
  input  logic                     pend_set,
  input  logic [ADDR_W-1:0]        pend_addr,
  output logic                     init_busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  // The clear index has one extra bit, so the count can reach DEPTH.
  localparam logic [ADDR_W:0] LP_LAST = (ADDR_W + 1)'(DEPTH - 1);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [ADDR_W:0]    r_idx;
  logic [ADDR_W:0]    w_idx_next;

  logic [DATA_W-1:0]  r_mem [DEPTH];
  logic [DEPTH-1:0]   r_pend;
  logic [DEPTH-1:0]   w_pend_next;

  logic               w_ready;
  logic               w_waddr_zero;
  logic               w_wr_act;

  assign w_ready   = (r_state == ST_READY);
  assign init_busy = ~w_ready;

  // A write takes effect only in READY. It is also dropped when it targets
  // the hardwired zero register. Bypass and pend-clear use this same
  // qualified write, so a discarded write is never forwarded.
  assign w_waddr_zero = (ZERO_REG != 0) && (waddr == '0);
  assign w_wr_act     = w_ready & wen & ~w_waddr_zero;

  // ---------------------------------------------------------------------------
  // Clear-engine FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_CLEAR;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    case (r_state)
      ST_CLEAR: begin
        w_idx_next = r_idx + 1'b1;
        // The edge that clears the last register also leaves CLEAR.
        if (r_idx == LP_LAST) begin
          w_state_next = ST_READY;
        end
      end
      ST_READY: begin
        // Only rst leaves READY.
      end
      default: begin
        w_state_next = ST_CLEAR;
        w_idx_next   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Storage array
  // ---------------------------------------------------------------------------
  // The array is never reset. The clear engine zeroes it one register per
  // cycle. While rst is held the FSM stays in CLEAR with idx 0, so the
  // only effect is that register 0 is rewritten with 0.
  always_ff @(posedge clk) begin
    if (!w_ready) begin
      r_mem[r_idx[ADDR_W-1:0]] <= '0;
    end else if (w_wr_act) begin
      r_mem[waddr] <= wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Pending scoreboard
  // ---------------------------------------------------------------------------
  // Each register's next pend bit is built on its own. The set term is
  // ORed in last, so a new producer beats a retiring write on the same edge.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_pend
    localparam logic [ADDR_W-1:0] LP_A = ADDR_W'(gi);

    logic w_set;
    logic w_clr;

    assign w_set = w_ready & pend_set & (pend_addr == LP_A)
                 & ~((ZERO_REG != 0) && (gi == 0));
    assign w_clr = w_wr_act & (waddr == LP_A);

    assign w_pend_next[gi] = w_set | (r_pend[gi] & ~w_clr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend <= '0;
    end else begin
      r_pend <= w_pend_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports
  // ---------------------------------------------------------------------------
  // The read ports are combinational. rst holds r_state in CLEAR, so the
  // ~w_ready gate also forces the outputs to 0 during reset.
  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    logic [ADDR_W-1:0] w_ra;
    logic              w_ra_zero;
    logic              w_hit;
    logic [DATA_W-1:0] w_data;

    assign w_ra      = raddr[gi*ADDR_W +: ADDR_W];
    assign w_ra_zero = (ZERO_REG != 0) && (w_ra == '0);
    assign w_hit     = w_wr_act && (waddr == w_ra);

    always_comb begin
      w_data = r_mem[w_ra];
      if (!w_ready || w_ra_zero) begin
        w_data = '0;
      end else if (w_hit) begin
        w_data = wdata;
      end
    end

    assign rdata[gi*DATA_W +: DATA_W] = w_data;

    // A register being written this cycle is already bypassed, so it is
    // not reported as pending.
    assign rd_pend[gi] = w_ready & ~w_ra_zero & r_pend[w_ra] & ~w_hit;
  end

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

  // -------------------------------------------------------------------------
  // Clock
  // -------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // -------------------------------------------------------------------------
  // DUT 1: default parameters (32x32, two read ports, zero register)
  // -------------------------------------------------------------------------
  logic        rst1;
  logic        wen1;
  logic [4:0]  waddr1;
  logic [31:0] wdata1;
  logic [9:0]  raddr1;
  logic [63:0] rdata1;
  logic [1:0]  rd_pend1;
  logic        pend_set1;
  logic [4:0]  pend_addr1;
  logic        busy1;

  regfile_mp dut1 (
    .clk       (clk),
    .rst       (rst1),
    .wen       (wen1),
    .waddr     (waddr1),
    .wdata     (wdata1),
    .raddr     (raddr1),
    .rdata     (rdata1),
    .rd_pend   (rd_pend1),
    .pend_set  (pend_set1),
    .pend_addr (pend_addr1),
    .init_busy (busy1)
  );

  // -------------------------------------------------------------------------
  // DUT 2: 16 registers, three read ports
  // -------------------------------------------------------------------------
  logic        rst2;
  logic        wen2;
  logic [3:0]  waddr2;
  logic [31:0] wdata2;
  logic [11:0] raddr2;
  logic [95:0] rdata2;
  logic [2:0]  rd_pend2;
  logic        pend_set2;
  logic [3:0]  pend_addr2;
  logic        busy2;

  regfile_mp #(.DATA_W(32), .ADDR_W(4), .NUM_RD(3), .ZERO_REG(1)) dut2 (
    .clk       (clk),
    .rst       (rst2),
    .wen       (wen2),
    .waddr     (waddr2),
    .wdata     (wdata2),
    .raddr     (raddr2),
    .rdata     (rdata2),
    .rd_pend   (rd_pend2),
    .pend_set  (pend_set2),
    .pend_addr (pend_addr2),
    .init_busy (busy2)
  );

  // -------------------------------------------------------------------------
  // Scoreboard
  // Stimulus pushes expectations. The monitor pops them on the next negedge.
  // kind: 0 = rdata, 1 = rd_pend, 2 = init_busy
  // -------------------------------------------------------------------------
  typedef struct {
    int          kind;
    int          dut;
    int          port;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  function automatic logic [31:0] get_act(input int kind, input int dut, input int port);
    logic [31:0] v;
    v = '0;
    if (dut == 0) begin
      case (kind)
        0:       v = rdata1[port*32 +: 32];
        1:       v = {31'd0, rd_pend1[port]};
        default: v = {31'd0, busy1};
      endcase
    end else begin
      case (kind)
        0:       v = rdata2[port*32 +: 32];
        1:       v = {31'd0, rd_pend2[port]};
        default: v = {31'd0, busy2};
      endcase
    end
    return v;
  endfunction

  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] a;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      a = get_act(e.kind, e.dut, e.port);
      total++;
      if (a !== e.exp) begin
        bad++;
        $display("FAIL %s: got %h want %h", e.name, a, e.exp);
      end else begin
        $display("ok   %s: %h", e.name, a);
      end
    end
  end

  task automatic expect_v(input int kind, input int dut, input int port,
                          input logic [31:0] v, input string n);
    exp_t e;
    e.kind = kind; e.dut = dut; e.port = port; e.exp = v; e.name = n;
    sb_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ra1(input logic [4:0] a0, input logic [4:0] a1);
    raddr1 = {a1, a0};
  endtask

  task automatic set_ra2(input logic [3:0] a0, input logic [3:0] a1, input logic [3:0] a2);
    raddr2 = {a2, a1, a0};
  endtask

  task automatic expect_clear2(input string n);
    expect_v(2, 1, 0, 32'd1, {n, " busy2"});
    for (int p = 0; p < 3; p++) expect_v(0, 1, p, 32'd0, $sformatf("%s rdata2[%0d]", n, p));
    for (int p = 0; p < 3; p++) expect_v(1, 1, p, 32'd0, $sformatf("%s rd_pend2[%0d]", n, p));
  endtask

  // Watchdog: the bench must always end on its own.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  // -------------------------------------------------------------------------
  // Directed stimulus
  // -------------------------------------------------------------------------
  initial begin
    rst1 = 1'b1; wen1 = 1'b0; waddr1 = '0; wdata1 = '0; raddr1 = '0;
    pend_set1 = 1'b0; pend_addr1 = '0;
    rst2 = 1'b1; wen2 = 1'b0; waddr2 = '0; wdata2 = '0; raddr2 = '0;
    pend_set2 = 1'b0; pend_addr2 = '0;
    step(); step();

    // ---- DUT1 reset state. Writes and pend_set are driven but must be ignored.
    wen1 = 1'b1; waddr1 = 5'd3; wdata1 = 32'hDEADBEEF;
    pend_set1 = 1'b1; pend_addr1 = 5'd3;
    set_ra1(5'd3, 5'd3);
    expect_v(2, 0, 0, 32'd1, "rst busy1");
    expect_v(0, 0, 0, 32'd0, "rst rdata1[0]");
    expect_v(0, 0, 1, 32'd0, "rst rdata1[1]");
    expect_v(1, 0, 0, 32'd0, "rst rd_pend1[0]");
    step();

    // ---- Clear sequence: busy is high for exactly 32 cycles.
    rst1 = 1'b0;
    for (int i = 0; i < 32; i++) begin
      expect_v(2, 0, 0, 32'd1, $sformatf("clear c%0d busy1", i));
      expect_v(0, 0, 0, 32'd0, $sformatf("clear c%0d rdata1[0]", i));
      step();
    end
    wen1 = 1'b0; pend_set1 = 1'b0;
    #1;
    total++;
    if (busy1 !== 1'b0) begin
      bad++;
      $display("FAIL direct busy1 after clear: got %b want 0", busy1);
    end else begin
      $display("ok   direct busy1 after clear: %b", busy1);
    end
    expect_v(2, 0, 0, 32'd0, "clear done busy1");
    expect_v(0, 0, 0, 32'd0, "reg3 after clear");
    expect_v(1, 0, 0, 32'd0, "reg3 not pending after clear");
    step();
    wen1 = 1'b1; waddr1 = 5'd3; wdata1 = 32'hDEADBEEF;
    expect_v(0, 0, 0, 32'hDEADBEEF, "reg3 write bypass");
    step();
    wen1 = 1'b0;
    #1;
    total++;
    if (rdata1[31:0] !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL direct reg3 readback: got %h want deadbeef", rdata1[31:0]);
    end else begin
      $display("ok   direct reg3 readback: %h", rdata1[31:0]);
    end
    expect_v(0, 0, 0, 32'hDEADBEEF, "reg3 readback");
    step();

    // ---- Bypass
    wen1 = 1'b1; waddr1 = 5'd5; wdata1 = 32'h11111111; set_ra1(5'd5, 5'd3);
    expect_v(0, 0, 0, 32'h11111111, "byp first write port0");
    expect_v(0, 0, 1, 32'hDEADBEEF, "byp other port unaffected");
    step();
    wdata1 = 32'h22222222; set_ra1(5'd5, 5'd5);
    expect_v(0, 0, 0, 32'h22222222, "byp same cycle port0");
    expect_v(0, 0, 1, 32'h22222222, "byp same cycle port1");
    step();
    wen1 = 1'b0;
    expect_v(0, 0, 0, 32'h22222222, "byp after edge port0");
    expect_v(0, 0, 1, 32'h22222222, "byp after edge port1");
    step();

    // ---- Zero register
    wen1 = 1'b1; waddr1 = 5'd0; wdata1 = 32'hFFFFFFFF;
    pend_set1 = 1'b1; pend_addr1 = 5'd0; set_ra1(5'd0, 5'd0);
    expect_v(0, 0, 0, 32'd0, "zero during rdata0");
    expect_v(0, 0, 1, 32'd0, "zero during rdata1");
    expect_v(1, 0, 0, 32'd0, "zero during rd_pend0");
    step();
    wen1 = 1'b0; pend_set1 = 1'b0;
    expect_v(0, 0, 0, 32'd0, "zero after rdata0");
    expect_v(1, 0, 0, 32'd0, "zero after rd_pend0");
    step();

    // ---- Scoreboard on reg 7
    pend_set1 = 1'b1; pend_addr1 = 5'd7; set_ra1(5'd7, 5'd7);
    expect_v(1, 0, 0, 32'd0, "pend7 not yet set");
    step();
    pend_set1 = 1'b0;
    expect_v(1, 0, 0, 32'd1, "pend7 set port0");
    expect_v(1, 0, 1, 32'd1, "pend7 set port1");
    step();
    wen1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h00000077; set_ra1(5'd7, 5'd5);
    expect_v(1, 0, 0, 32'd0, "pend7 masked by write");
    expect_v(0, 0, 0, 32'h00000077, "reg7 bypass");
    expect_v(1, 0, 1, 32'd0, "reg5 not pending");
    expect_v(0, 0, 1, 32'h22222222, "reg5 port1 independent");
    step();
    wen1 = 1'b0; set_ra1(5'd7, 5'd7);
    expect_v(1, 0, 0, 32'd0, "pend7 cleared");
    expect_v(0, 0, 0, 32'h00000077, "reg7 readback");
    step();

    // ---- Set/clear collision on reg 9
    pend_set1 = 1'b1; pend_addr1 = 5'd9; set_ra1(5'd9, 5'd9);
    expect_v(1, 0, 1, 32'd0, "pend9 not yet set");
    step();
    pend_set1 = 1'b0;
    expect_v(1, 0, 1, 32'd1, "pend9 set");
    step();
    pend_set1 = 1'b1; wen1 = 1'b1; waddr1 = 5'd9; wdata1 = 32'h00000099;
    expect_v(1, 0, 1, 32'd0, "collision masked by bypass");
    expect_v(0, 0, 1, 32'h00000099, "collision bypass data");
    step();
    pend_set1 = 1'b0; wen1 = 1'b0;
    expect_v(1, 0, 1, 32'd1, "collision set wins port1");
    expect_v(1, 0, 0, 32'd1, "collision set wins port0");
    expect_v(0, 0, 1, 32'h00000099, "reg9 readback");
    step();
    wen1 = 1'b1; wdata1 = 32'h000000AA;
    step();
    wen1 = 1'b0;
    expect_v(1, 0, 1, 32'd0, "pend9 retired");
    expect_v(0, 0, 1, 32'h000000AA, "reg9 second value");
    step();

    // ---- DUT2 reset state, then full clear, then populate registers
    set_ra2(4'd1, 4'd2, 4'd3);
    expect_clear2("rst2 held");
    step();
    rst2 = 1'b0;
    for (int i = 0; i < 16; i++) step();
    total++;
    if (busy2 !== 1'b0) begin
      bad++;
      $display("FAIL direct dut2 ready: got %b want 0", busy2);
    end else begin
      $display("ok   direct dut2 ready: %b", busy2);
    end
    expect_v(2, 1, 0, 32'd0, "dut2 ready");
    for (int r = 1; r < 16; r++) begin
      wen2 = 1'b1; waddr2 = 4'(r); wdata2 = 32'hA0 + 32'(r);
      step();
    end
    wen2 = 1'b0;
    expect_v(0, 1, 2, 32'hA3, "dut2 reg3 populated");
    step();

    // ---- Reset from READY, then reset again at clear cycle 6
    rst2 = 1'b1;
    expect_clear2("rst2 from ready");
    step();
    rst2 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      expect_clear2($sformatf("clr2a c%0d", i));
      step();
    end
    rst2 = 1'b1;
    expect_clear2("rst2 mid clear");
    step();
    rst2 = 1'b0;
    wen2 = 1'b1; waddr2 = 4'd1; wdata2 = 32'h55555555;
    pend_set2 = 1'b1; pend_addr2 = 4'd2;
    for (int i = 0; i < 16; i++) begin
      expect_clear2($sformatf("clr2b c%0d", i));
      step();
    end
    wen2 = 1'b0; pend_set2 = 1'b0;
    #1;
    total++;
    if (busy2 !== 1'b0) begin
      bad++;
      $display("FAIL direct dut2 ready again: got %b want 0", busy2);
    end else begin
      $display("ok   direct dut2 ready again: %b", busy2);
    end
    expect_v(2, 1, 0, 32'd0, "dut2 ready again");
    for (int r = 0; r < 16; r += 3) begin
      set_ra2(4'(r), 4'((r + 1) % 16), 4'((r + 2) % 16));
      for (int p = 0; p < 3; p++)
        expect_v(0, 1, p, 32'd0, $sformatf("dut2 reg%0d cleared", (r + p) % 16));
      expect_v(1, 1, 1, 32'd0, "dut2 no pend after clear");
      step();
    end

    step();
    step();
    if (bad != 0) begin
      $display("FAIL summary: got bad=%0d want 0 (total=%0d)", bad, total);
    end else begin
      $display("ok   summary: total=%0d bad=%0d", total, bad);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-read-port general-purpose register file for the pipelined MIPS-lite core.
- Supersedes the fixed 32x32, two-read-port file.
- Adds generic width/depth and read-port count, an optional hardwired zero register, and write-to-read bypass on every port.
- Also adds a post-reset sequential clear engine and a per-register pending scoreboard, which the decode stage uses for hazard stalls.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers
NUM_RD, 2, number of combinational read ports (1..4)
ZERO_REG, 1, 1 = register 0 reads as 0, is never written and is never pending

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
wen  input  1  write enable (writeback stage)
waddr  input  ADDR_W  write address
wdata  input  DATA_W  write data
raddr  input  NUM_RD*ADDR_W  read addresses; port k occupies bits [k*ADDR_W +: ADDR_W]
rdata  output  NUM_RD*DATA_W  read data; port k occupies bits [k*DATA_W +: DATA_W]
rd_pend  output  NUM_RD  per-port flag: addressed register awaits an in-flight write
pend_set  input  1  mark register pend_addr as pending (decode issues a producer)
pend_addr  input  ADDR_W  register to mark pending
init_busy  output  1  clear engine active; core must stall while high

Behaviour:
- Reset: one clock, clk; reset rst, asynchronous and active-high.
- While rst=1:
  - FSM forced to CLEAR with clear index = 0.
  - All pending bits = 0; init_busy = 1.
  - rdata = 0 on all ports; rd_pend = 0.
- FSM states:
  - CLEAR: each clk edge writes 0 to reg[idx], then idx += 1. After the edge that writes idx = DEPTH-1, go to READY. CLEAR therefore takes exactly DEPTH cycles after rst deasserts.
  - READY: normal operation. There is no path back to CLEAR except rst.
- During CLEAR:
  - init_busy = 1; rdata = 0 on all ports; rd_pend = 0.
  - wen and pend_set are ignored; nothing is written or marked.
- rst asserted mid-CLEAR: clearing restarts from idx 0 and takes the full DEPTH cycles again.
- Write (READY): on a clk edge with wen=1, reg[waddr] <= wdata. If ZERO_REG=1 and waddr=0, the write is discarded.
- Read (READY), combinational, each port k evaluated independently:
  - ZERO_REG=1 and raddr_k = 0 -> 0.
  - Else if wen=1 and waddr = raddr_k (and the write is not discarded) -> wdata (same-cycle bypass).
  - Else -> reg[raddr_k].
  - Several ports may hit the same address or the bypass simultaneously; all return the same value.
- Scoreboard (READY), one pend bit per register:
  - Clear: a write with wen=1 clears pend[waddr] at the clk edge.
  - Set: pend_set=1 sets pend[pend_addr] at the clk edge.
  - Same edge, same address, both set and clear: set wins (a new producer overrides the retiring one).
  - ZERO_REG=1: pend[0] is held 0 and pend_set to address 0 is ignored.
- rd_pend_k = pend[raddr_k] AND NOT (wen=1 and waddr = raddr_k). A register being written this cycle is bypassed, so it is not reported as pending. Forced 0 when raddr_k = 0 with ZERO_REG=1.
- Latency:
  - Reads and rd_pend: 0 cycles.
  - Writes and pend updates: visible through the array from the cycle after the edge; visible via bypass in the same cycle.
- Widths: data is never extended or truncated. The clear index is ADDR_W+1 bits so the terminal count at DEPTH is detectable.

Test Plan:
- Clear sequence: pulse rst, release, drive wen=1 waddr=3 wdata=0xDEADBEEF every cycle. init_busy stays 1 for exactly 32 cycles, then 0. Reading reg 3 then returns 0 because writes during CLEAR were dropped. Next write lands and reads back 0xDEADBEEF.
- Bypass: READY, reg5 = 0x11111111. In the same cycle wen=1 waddr=5 wdata=0x22222222 with raddr0=raddr1=5. Both ports read 0x22222222 that cycle and 0x22222222 after the edge.
- Zero register: wen=1 waddr=0 wdata=0xFFFFFFFF, pend_set=1 pend_addr=0, raddr0=0. rdata0=0 and rd_pend0=0 both during and after the edge.
- Scoreboard: pend_set on reg 7 -> rd_pend=1 for raddr=7 on later cycles. A cycle with wen=1 waddr=7 shows rd_pend=0 combinationally. After that edge pend[7]=0.
- Set/clear collision: the same edge has pend_set=1 pend_addr=9 and wen=1 waddr=9 with pend[9] already 1. After the edge pend[9]=1, so rd_pend=1 for raddr=9 once wen drops.
- Reset mid-clear with NUM_RD=3, ADDR_W=4: assert rst at clear cycle 6 of 16, release. init_busy=1 for a further 16 full cycles. All three rdata ports = 0 throughout, all registers read 0 afterwards.
